seven_seg_reader: RTL and testbench
===================================

Name: seven_seg_reader

Overview:
- Reverse direction of the team's 4-bit-to-7-segment decoders: monitors a multiplexed 7-segment display bus (one-hot digit enable plus segment lines) and recovers the hex nibble shown on each digit.
- Used on the bench and in loopback designs to check what a display driver actually emits.
- Filters glitches with a stability counter, decodes segment patterns to nibbles, flags illegal patterns, and publishes a complete frame once every digit has been captured.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a capture (2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- an  input  NUM_DIGITS  digit enable, active-high, expected one-hot; bit i selects digit i.
- seg  input  7  segment lines, active-high, seg[6:0] = g,f,e,d,c,b,a.
- cap_strobe  output  1  one-cycle pulse: a digit was captured this cycle.
- cap_index  output  3  index of the digit captured (valid with cap_strobe).
- live_digits  output  4*NUM_DIGITS  latest nibble per digit; digit i at bits [4i+3:4i].
- live_err  output  NUM_DIGITS  per digit: 1 = last captured pattern was illegal.
- frame_valid  output  1  one-cycle pulse: all digits captured since the last frame.
- frame_digits  output  4*NUM_DIGITS  snapshot of live_digits taken at frame_valid.
- frame_err  output  1  OR of live_err at snapshot time.

Behaviour:
- Reset (asynchronous, immediate): all outputs 0; sample register 0; stability count 0; seen_mask 0.
- Sampling:
  - {an,seg} is registered on every rising edge.
  - If the new sample differs from the previous one, count = 1.
  - Otherwise count = min(count+1, STABLE_CYCLES).
- Capture:
  - A capture occurs only on the edge where count becomes exactly STABLE_CYCLES and the sample's an is one-hot.
  - The sample must then change before another capture can occur.
  - Capture timing: if inputs are applied before edge 1 and held, the capture takes effect at edge STABLE_CYCLES. cap_strobe is high for the following cycle only.
  - an all-zero or multi-hot: sample ignored; no capture, no error. The count still runs.
- Decode table (seg hex -> nibble):
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7
  - 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F
  - Any other pattern: nibble 0, live_err[i] = 1.
  - A legal pattern clears live_err[i].
- Capture updates, registered and all on the same edge: live_digits slice i, live_err[i], cap_index, seen_mask[i] = 1.
- Recapturing an already-seen digit before the frame completes overwrites its nibble and error bit; seen_mask is unchanged.
- Frame completion (capture makes seen_mask all ones), on the same edge:
  - frame_valid pulses with cap_strobe.
  - frame_digits and frame_err load from the post-capture live values.
  - seen_mask clears to 0.
- frame_digits and frame_err hold between frames.
- Reset mid-count or mid-frame: partial frame discarded, outputs zeroed; the next frame needs every digit again.
- State view (two-state FSM):
  - SETTLING (count < STABLE_CYCLES): goes to HELD when count reaches STABLE_CYCLES.
  - HELD: goes back to SETTLING on any sample change.
  - The capture decision is made on the SETTLING->HELD transition.
- cap_index width is fixed at 3; bits above the digit range are 0.

Test Plan:
- Clean scan: NUM_DIGITS=4, STABLE_CYCLES=4; drive an=0001/seg=06, an=0010/seg=5B, an=0100/seg=4F, an=1000/seg=66, each held 10 cycles -> four cap_strobe pulses with cap_index 0,1,2,3. frame_valid on the 4th capture; frame_digits=16'h4321, frame_err=0.
- Glitch rejection: an=0001/seg=7F held 3 cycles, then seg=6F held 3 cycles -> no cap_strobe. Hold seg=6F one more cycle -> capture at that edge, live_digits[3:0]=9.
- Illegal pattern: an=0100/seg=7E held 4 cycles -> live_err[2]=1, nibble 0. Then seg=7C held 4 -> nibble B, live_err[2]=0. Completing a frame while any live_err bit is set -> frame_err=1.
- Enable faults: an=0000 and an=0110 with seg=3F, each held 20 cycles -> no cap_strobe, seen_mask unchanged, no frame_valid.
- Recapture and reset: capture digit0=5, recapture digit0=A, then capture digits 1-3 -> frame_digits[3:0]=A. Assert rst mid-frame after two captures -> all outputs 0 immediately; a full four-digit scan is needed before the next frame_valid.

Source files
------------

// File: rtl/seven_seg_reader.sv
// rtl/seven_seg_reader.sv - recovers hex nibbles from a multiplexed 7-segment display bus
// Debounces each {an,seg} sample, decodes captured digits and publishes complete frames.

module seven_seg_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic                    cap_strobe,
    output logic [2:0]              cap_index,
    output logic [4*NUM_DIGITS-1:0] live_digits,
    output logic [NUM_DIGITS-1:0]   live_err,
    output logic                    frame_valid,
    output logic [4*NUM_DIGITS-1:0] frame_digits,
    output logic                    frame_err
);

    localparam int              SW     = NUM_DIGITS + 7;
    localparam logic [7:0]      STABLE = 8'(STABLE_CYCLES);

    typedef enum logic {SETTLING, HELD} state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           sample_q, sample_d;
    logic [7:0]              count_q, count_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    cap_strobe_q, cap_strobe_d;
    logic [2:0]              cap_index_q, cap_index_d;
    logic [4*NUM_DIGITS-1:0] live_digits_q, live_digits_d;
    logic [NUM_DIGITS-1:0]   live_err_q, live_err_d;
    logic                    frame_valid_q, frame_valid_d;
    logic [4*NUM_DIGITS-1:0] frame_digits_q, frame_digits_d;
    logic                    frame_err_q, frame_err_d;

    logic [NUM_DIGITS-1:0]   s_an;
    logic [6:0]              s_seg;
    logic [4:0]              dec;
    logic [2:0]              idx;
    logic                    capture;

    // Returns {illegal, nibble}; unknown patterns decode to nibble 0.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F: decode = 5'h00;
            7'h06: decode = 5'h01;
            7'h5B: decode = 5'h02;
            7'h4F: decode = 5'h03;
            7'h66: decode = 5'h04;
            7'h6D: decode = 5'h05;
            7'h7D: decode = 5'h06;
            7'h07: decode = 5'h07;
            7'h7F: decode = 5'h08;
            7'h6F: decode = 5'h09;
            7'h77: decode = 5'h0A;
            7'h7C: decode = 5'h0B;
            7'h39: decode = 5'h0C;
            7'h5E: decode = 5'h0D;
            7'h79: decode = 5'h0E;
            7'h71: decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    always_comb begin
        sample_d       = {an, seg};
        count_d        = count_q;
        seen_d         = seen_q;
        cap_strobe_d   = 1'b0;
        cap_index_d    = cap_index_q;
        live_digits_d  = live_digits_q;
        live_err_d     = live_err_q;
        frame_valid_d  = 1'b0;
        frame_digits_d = frame_digits_q;
        frame_err_d    = frame_err_q;
        idx            = 3'd0;

        if (sample_d != sample_q) begin
            count_d = 8'd1;
        end else if (count_q < STABLE) begin
            count_d = count_q + 8'd1;
        end

        state_d = (count_d == STABLE) ? HELD : SETTLING;

        s_an  = sample_d[SW-1:7];
        s_seg = sample_d[6:0];
        dec   = decode(s_seg);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (s_an[i]) begin
                idx = 3'(i);
            end
        end

        // Only the settle-to-held transition captures, so a steady sample is taken once.
        capture = (state_q == SETTLING) && (state_d == HELD) && $onehot(s_an);

        if (capture) begin
            cap_strobe_d = 1'b1;
            cap_index_d  = idx;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (s_an[i]) begin
                    live_digits_d[4*i +: 4] = dec[3:0];
                    live_err_d[i]           = dec[4];
                    seen_d[i]               = 1'b1;
                end
            end
            if (&seen_d) begin
                frame_valid_d  = 1'b1;
                frame_digits_d = live_digits_d;
                frame_err_d    = |live_err_d;
                seen_d         = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= SETTLING;
            sample_q       <= '0;
            count_q        <= '0;
            seen_q         <= '0;
            cap_strobe_q   <= 1'b0;
            cap_index_q    <= '0;
            live_digits_q  <= '0;
            live_err_q     <= '0;
            frame_valid_q  <= 1'b0;
            frame_digits_q <= '0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sample_q       <= sample_d;
            count_q        <= count_d;
            seen_q         <= seen_d;
            cap_strobe_q   <= cap_strobe_d;
            cap_index_q    <= cap_index_d;
            live_digits_q  <= live_digits_d;
            live_err_q     <= live_err_d;
            frame_valid_q  <= frame_valid_d;
            frame_digits_q <= frame_digits_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign cap_strobe   = cap_strobe_q;
    assign cap_index    = cap_index_q;
    assign live_digits  = live_digits_q;
    assign live_err     = live_err_q;
    assign frame_valid  = frame_valid_q;
    assign frame_digits = frame_digits_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// tb/tb_seven_seg_reader.sv - scoreboard bench for seven_seg_reader
// Stimulus queues expected captures/frames; a negedge monitor pops and compares.

module tb_seven_seg_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        cap_strobe;
    logic [2:0]  cap_index;
    logic [15:0] live_digits;
    logic [3:0]  live_err;
    logic        frame_valid;
    logic [15:0] frame_digits;
    logic        frame_err;

    typedef struct {
        int         idx;
        logic [3:0] nib;
        logic       err;
    } cap_t;

    typedef struct {
        logic [15:0] digits;
        logic        err;
    } frame_t;

    cap_t   cap_q[$];
    frame_t frame_q[$];
    int     errors = 0;
    int     checks = 0;

    seven_seg_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .an           (an),
        .seg          (seg),
        .cap_strobe   (cap_strobe),
        .cap_index    (cap_index),
        .live_digits  (live_digits),
        .live_err     (live_err),
        .frame_valid  (frame_valid),
        .frame_digits (frame_digits),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got pulse expected none", name);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (cap_strobe) begin
                if (cap_q.size() == 0) begin
                    flag("unexpected cap_strobe");
                end else begin
                    cap_t   c;
                    logic [3:0] nib;
                    c   = cap_q.pop_front();
                    nib = live_digits[4*c.idx +: 4];
                    check("cap_index", 32'(cap_index), 32'(c.idx));
                    check("cap_nibble", 32'(nib), 32'(c.nib));
                    check("cap_err", 32'(live_err[c.idx]), 32'(c.err));
                end
            end
            if (frame_valid) begin
                if (frame_q.size() == 0) begin
                    flag("unexpected frame_valid");
                end else begin
                    frame_t f;
                    f = frame_q.pop_front();
                    check("frame_digits", 32'(frame_digits), 32'(f.digits));
                    check("frame_err", 32'(frame_err), 32'(f.err));
                end
            end
        end
    end

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n,
                        input bit exp_cap, input int idx, input logic [3:0] nib, input logic e);
        if (exp_cap) cap_q.push_back('{idx: idx, nib: nib, err: e});
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " cap_strobe"}, 32'(cap_strobe), 32'h0);
        check({tag, " cap_index"}, 32'(cap_index), 32'h0);
        check({tag, " live_digits"}, 32'(live_digits), 32'h0);
        check({tag, " live_err"}, 32'(live_err), 32'h0);
        check({tag, " frame_valid"}, 32'(frame_valid), 32'h0);
        check({tag, " frame_digits"}, 32'(frame_digits), 32'h0);
        check({tag, " frame_err"}, 32'(frame_err), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        an  = 4'h0;
        seg = 7'h00;
        #2;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Clean scan
        hold(4'b0001, 7'h06, 10, 1, 0, 4'h1, 1'b0);
        hold(4'b0010, 7'h5B, 10, 1, 1, 4'h2, 1'b0);
        hold(4'b0100, 7'h4F, 10, 1, 2, 4'h3, 1'b0);
        frame_q.push_back('{digits: 16'h4321, err: 1'b0});
        hold(4'b1000, 7'h66, 10, 1, 3, 4'h4, 1'b0);

        // Glitch rejection: two 3-cycle runs, then the fourth stable edge captures
        hold(4'b0001, 7'h7F, 3, 0, 0, 4'h0, 1'b0);
        hold(4'b0001, 7'h6F, 3, 0, 0, 4'h0, 1'b0);
        hold(4'b0001, 7'h6F, 1, 1, 0, 4'h9, 1'b0);
        check("glitch live_digits[3:0]", 32'(live_digits[3:0]), 32'h9);
        hold(4'b0001, 7'h6F, 5, 0, 0, 4'h0, 1'b0);

        // Illegal patterns and frame_err
        hold(4'b0100, 7'h7E, 4, 1, 2, 4'h0, 1'b1);
        check("illegal live_err[2]", 32'(live_err[2]), 32'h1);
        hold(4'b0100, 7'h7C, 4, 1, 2, 4'hB, 1'b0);
        check("legal clears live_err[2]", 32'(live_err[2]), 32'h0);
        hold(4'b0010, 7'h00, 4, 1, 1, 4'h0, 1'b1);
        frame_q.push_back('{digits: 16'h0B09, err: 1'b1});
        hold(4'b1000, 7'h3F, 4, 1, 3, 4'h0, 1'b0);

        // Enable faults
        hold(4'b0000, 7'h3F, 20, 0, 0, 4'h0, 1'b0);
        hold(4'b0110, 7'h3F, 20, 0, 0, 4'h0, 1'b0);

        // Recapture of digit 0 before the frame completes
        hold(4'b0001, 7'h6D, 6, 1, 0, 4'h5, 1'b0);
        hold(4'b0001, 7'h77, 6, 1, 0, 4'hA, 1'b0);
        hold(4'b0010, 7'h06, 6, 1, 1, 4'h1, 1'b0);
        hold(4'b0100, 7'h5B, 6, 1, 2, 4'h2, 1'b0);
        frame_q.push_back('{digits: 16'h721A, err: 1'b0});
        hold(4'b1000, 7'h07, 6, 1, 3, 4'h7, 1'b0);
        check("recapture frame_digits[3:0]", 32'(frame_digits[3:0]), 32'hA);

        // Reset mid-frame, then a full scan starting from digits 2 and 3
        hold(4'b0001, 7'h4F, 6, 1, 0, 4'h3, 1'b0);
        hold(4'b0010, 7'h79, 6, 1, 1, 4'hE, 1'b0);
        hold(4'b0100, 7'h5B, 2, 0, 0, 4'h0, 1'b0);
        #3 rst = 1'b1;
        #1;
        check_zero("midframe reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        hold(4'b0100, 7'h5E, 6, 1, 2, 4'hD, 1'b0);
        hold(4'b1000, 7'h71, 6, 1, 3, 4'hF, 1'b0);
        hold(4'b0001, 7'h7F, 6, 1, 0, 4'h8, 1'b0);
        frame_q.push_back('{digits: 16'hFDC8, err: 1'b0});
        hold(4'b0010, 7'h39, 6, 1, 1, 4'hC, 1'b0);

        hold(4'b0000, 7'h00, 8, 0, 0, 4'h0, 1'b0);
        check("frame_digits held", 32'(frame_digits), 32'hFDC8);
        check("pending captures", 32'(cap_q.size()), 32'h0);
        check("pending frames", 32'(frame_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
